mul_pipe: RTL

MUL_PIPE -- requirements
Module: mul_pipe

---
 rtl/mul_pkg.sv | 31 +++
 rtl/mul_stage.sv | 50 +++++
 rtl/mul_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared definitions for the pipelined multiplier: in_op
//               encodings and the legal pipeline-depth bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // in_op encodings
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;  // low half
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;  // high half, signed x signed
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;  // high half, signed x unsigned
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;  // high half, unsigned x unsigned

    // Legal range for the LATENCY parameter of mul_pipe
    localparam int MUL_LATENCY_MIN = 1;
    localparam int MUL_LATENCY_MAX = 8;

    // True when rs1 must be sign-extended for this op
    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // True when rs2 must be sign-extended for this op
    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_stage.sv
`default_nettype none
// ============================================================================
// Module      : mul_stage
// Description : One valid/ready register slot. Loads when empty or when the
//               downstream slot takes the current entry. Only the valid bit
//               is reset/flushed; the payload register is left free-running.
// Ports       : clk, reset_n (sync, active-low), i_flush (clears valid),
//               i_valid/o_ready/i_data (upstream side),
//               o_valid/i_ready/o_data (downstream side)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot can accept when empty or when its entry leaves this same edge.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (o_ready && i_valid) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe
// Description : Pipelined RISC-V style multiplier (MUL/MULH/MULHSU/MULHU)
//               with valid/ready handshakes, pass-through tag and flush.
//               The full 2*XLEN product is formed on entry and carried down
//               LATENCY register slots; the result half is chosen at the end.
// Ports       : clk, reset_n (sync, active-low)
//               in_valid/in_ready/in_op/in_a/in_b/in_tag : request side
//               flush                                    : drop everything
//               out_valid/out_ready/out_result/out_tag   : result side
//               busy                                     : any slot occupied
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Payload layout: {hi_sel, tag, product[2*XLEN-1:0]}
    localparam int c_PROD_W = 2 * XLEN;
    localparam int c_PAY_W  = 1 + TAG_W + c_PROD_W;

    if ((LATENCY < MUL_LATENCY_MIN) || (LATENCY > MUL_LATENCY_MAX)) begin : g_bad_latency
        $error("mul_pipe: LATENCY out of range");
    end

    // ------------------------------------------------------------------
    // Operand extension and product. Each operand is widened to XLEN+1
    // bits (sign or zero per op) so one signed multiply covers all ops.
    // Only the low 2*XLEN product bits are ever needed, so the extended
    // operands are sign-extended further to 2*XLEN and multiplied at that
    // width: the low 2*XLEN bits are exact.
    // ------------------------------------------------------------------
    logic signed [XLEN:0]       w_a_ext;
    logic signed [XLEN:0]       w_b_ext;
    logic signed [c_PROD_W-1:0] w_a_wide;
    logic signed [c_PROD_W-1:0] w_b_wide;
    logic signed [c_PROD_W-1:0] w_prod;
    logic                       w_hi_sel;

    assign w_a_ext  = {op_a_signed(in_op) & in_a[XLEN-1], in_a};
    assign w_b_ext  = {op_b_signed(in_op) & in_b[XLEN-1], in_b};
    assign w_a_wide = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
    assign w_b_wide = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
    assign w_prod   = w_a_wide * w_b_wide;
    assign w_hi_sel = (in_op != MUL_OP_MUL);

    // ------------------------------------------------------------------
    // Slot chain. Index k is the input side of slot k; index LATENCY is
    // the output of the last slot.
    // ------------------------------------------------------------------
    logic               w_valid [0:LATENCY];
    logic               w_ready [0:LATENCY];
    logic [c_PAY_W-1:0] w_data  [0:LATENCY];

    // Requests are refused during reset and flush so nothing enters a
    // pipeline that is about to be cleared.
    assign in_ready           = w_ready[0] && reset_n && !flush;
    assign w_valid[0]         = in_valid && in_ready;
    assign w_data[0]          = {w_hi_sel, in_tag, w_prod};
    assign w_ready[LATENCY]   = out_ready;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        mul_stage #(
            .WIDTH (c_PAY_W)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .i_flush (flush),
            .i_valid (w_valid[gi]),
            .o_ready (w_ready[gi]),
            .i_data  (w_data[gi]),
            .o_valid (w_valid[gi+1]),
            .i_ready (w_ready[gi+1]),
            .o_data  (w_data[gi+1])
        );
    end

    // ------------------------------------------------------------------
    // Output: half selection, zeroed whenever no result is presented.
    // ------------------------------------------------------------------
    logic                w_last_hi;
    logic [TAG_W-1:0]    w_last_tag;
    logic [c_PROD_W-1:0] w_last_prod;

    assign w_last_hi   = w_data[LATENCY][c_PAY_W-1];
    assign w_last_tag  = w_data[LATENCY][c_PROD_W +: TAG_W];
    assign w_last_prod = w_data[LATENCY][c_PROD_W-1:0];

    assign out_valid  = w_valid[LATENCY];
    assign out_result = !out_valid ? '0 :
                        (w_last_hi ? w_last_prod[c_PROD_W-1:XLEN] : w_last_prod[XLEN-1:0]);
    assign out_tag    = out_valid ? w_last_tag : '0;

    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            busy = busy | w_valid[k];
        end
    end

endmodule
`default_nettype wire
